rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares one dual-port instruction ROM (two read ports A/B, 1-cycle registered read) among four cores.
- Each core issues fetch requests with a request/grant handshake.
- Up to two requests are granted per cycle, round-robin.
- The ROM word returns one cycle later, tagged to the winning core with a data-valid pulse.
- Sits between the core fetch units and the ROM instance in the memory subsystem.

Parameters:
- WIDTH, 32, core address and instruction word width.
- ROM_ADDR_WIDTH, 14, ROM address bits; the low bits of the core address are used.
- NUM_CORES, 4, number of requesters. Fixed at 4; other values are unsupported.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_core  input  4  per-core fetch request; bit i = core i.
- address_core0..address_core3  input  WIDTH each  fetch address; held stable while the corresponding req is high and ungranted.
- grant_core  output  4  per-core accept (combinational from req and priority state); the request is consumed in a cycle with req&grant.
- data_core0..data_core3  output  WIDTH each  registered returned instruction.
- valid_core  output  4  1-cycle pulse; data_core(i) is new this cycle.
- rom_address_a  output  ROM_ADDR_WIDTH  to ROM port A.
- rom_address_b  output  ROM_ADDR_WIDTH  to ROM port B.
- rom_q_a  input  WIDTH  ROM port A data, one cycle after address.
- rom_q_b  input  WIDTH  ROM port B data.

Behaviour:
- Reset values:
  - grant_core=0, valid_core=0.
  - data_core0..3=0.
  - rom_address_a/b=0.
  - priority pointer=0; in-flight tags cleared.
- Arbitration (cycle N):
  - Scan cores starting at the pointer, wrapping 3->0.
  - The first requester wins port A. The next requester in the same scan order wins port B.
  - Grants are at most 2 per cycle and never duplicate a core.
- Pointer update at the edge ending cycle N:
  - With ≥1 grant: pointer <= (index of last granted core + 1) mod 4.
  - With no grant: pointer unchanged.
- ROM drive:
  - rom_address_a = address of the A winner [ROM_ADDR_WIDTH-1:0]; B likewise.
  - An unused port drives 0.
- In-flight tags, registered at the edge ending N: {valid_a, core_a}, {valid_b, core_b}.
- Response (cycle N+1):
  - data_core(core_a) <= rom_q_a and valid_core[core_a]=1 for exactly one cycle; same for B.
  - data_core holds its last value until overwritten.
- Latency: grant in N -> valid in N+1.
- Throughput: a core may be granted on consecutive cycles when contention allows.
- A core with req low is never granted.
- Cores must not change address while req=1 and grant=0. Behaviour on violation: the address sampled in the grant cycle is used.
- Simultaneous events:
  - 4 requesters: 2 granted, the other 2 stall. The pointer update guarantees they win next cycle.
  - A re-request from a just-served core is queued behind older requesters by pointer order.
- Reset mid-operation: the in-flight response is discarded; no valid pulse after reset deasserts until a new grant.
- Only the low ROM_ADDR_WIDTH bits are used; the upper bits are ignored unless the optional feature is enabled.

Optional Feature:
- ROM_ADDR_RANGE_CHECK_EN defined:
  - Adds output addr_error_core[3:0].
  - A granted request with any nonzero address bit above ROM_ADDR_WIDTH-1 still occupies its port slot.
  - In N+1 that core gets data_core=0, valid_core pulse=1 and addr_error_core bit pulse=1. ROM data for that slot is dropped.
  - addr_error_core resets to 0.
- Undefined: no port; upper bits ignored; the ROM word is returned.

Decomposition:
- Shared package (memory subsystem):
  - constants NUM_CORES=4, ROM_ADDR_WIDTH=14, CORE_IDX_W=2;
  - typedef core_idx_t (2-bit);
  - typedef inflight_tag_t {valid, core_idx_t}.
- One natural sub-module: rr_pick2.
  - Combinational; inputs are the 4-bit req and the 2-bit pointer.
  - Outputs are {valid_a, idx_a, valid_b, idx_b} and the next pointer.
- The top holds the pointer, tags, address muxes and the response demux/registers.

Test Plan:
- Single request, after reset: req=0001, address_core0=0x5, ROM word[5]=0xA5A5 -> grant=0001 and rom_address_a=5 in N; valid=0001 and data_core0=0xA5A5 in N+1; port B idle at 0.
- Two requests: req=0110, pointer=0 -> core1 on A, core2 on B, grant=0110; next pointer=3; both valids pulse in N+1 with their own words.
- Full contention, req=1111 held for 4 cycles from pointer 0 -> grants 0011, 1100, 0011, 1100; every core receives one word per 2 cycles; no starvation.
- Wrap: pointer=3, req=1001 -> core3 on A, core0 on B; next pointer=1.
- Reset while in flight: grant core2 in N, reset asserted asynchronously mid-N+1 -> valid_core=0, data_core2=0, pointer=0; no valid pulse after release.
- With ROM_ADDR_RANGE_CHECK_EN: address_core1=0x0001_0003 -> in N+1, valid_core[1]=1, addr_error_core[1]=1, data_core1=0. Without the macro: data_core1 = ROM word[3].

Source files
------------

// File: rtl/rom_port_arbiter_pkg.sv
// rtl/rom_port_arbiter_pkg.sv - shared constants and types for the ROM port arbiter
//
// Purpose: constants and typedefs shared by the arbiter top and its pick logic.
//   NUM_CORES      : number of fetch requesters (fixed at 4)
//   ROM_ADDR_WIDTH : ROM word address bits
//   CORE_IDX_W     : bits needed to name one core
//   core_idx_t     : core index
//   inflight_tag_t : {valid, core} tag of a ROM read in flight
package rom_port_arbiter_pkg;

  localparam int NUM_CORES      = 4;
  localparam int ROM_ADDR_WIDTH = 14;
  localparam int CORE_IDX_W     = 2;

  typedef logic [CORE_IDX_W-1:0] core_idx_t;

  typedef struct packed {
    logic      valid;
    core_idx_t core;
  } inflight_tag_t;

endpackage

// File: rtl/rom_port_arbiter_rr_pick2.sv
// rtl/rom_port_arbiter_rr_pick2.sv - round-robin pick of up to two requesters
//
// Purpose: combinational scan of the request vector starting at the priority
// pointer (wrapping 3->0). First requester found wins port A, the next one
// wins port B. The next pointer is one past the last winner, or unchanged
// when nobody requests.
// Ports:
//   i_req      in  [NUM_CORES-1:0] request vector, bit i = core i
//   i_ptr      in  core_idx_t      current priority pointer
//   o_valid_a  out                 port A has a winner
//   o_idx_a    out core_idx_t      port A winner
//   o_valid_b  out                 port B has a winner
//   o_idx_b    out core_idx_t      port B winner
//   o_next_ptr out core_idx_t      pointer to load at the end of this cycle
module rr_pick2
  import rom_port_arbiter_pkg::*;
(
  input  logic [NUM_CORES-1:0] i_req,
  input  core_idx_t            i_ptr,
  output logic                 o_valid_a,
  output core_idx_t            o_idx_a,
  output logic                 o_valid_b,
  output core_idx_t            o_idx_b,
  output core_idx_t            o_next_ptr
);

  core_idx_t w_idx;

  always_comb begin
    o_valid_a  = 1'b0;
    o_idx_a    = '0;
    o_valid_b  = 1'b0;
    o_idx_b    = '0;
    o_next_ptr = i_ptr;
    w_idx      = '0;

    // Index arithmetic is 2 bits wide, so the scan wraps 3->0 for free.
    for (int k = 0; k < NUM_CORES; k++) begin
      w_idx = i_ptr + core_idx_t'(k);
      if (i_req[w_idx]) begin
        if (!o_valid_a) begin
          o_valid_a = 1'b1;
          o_idx_a   = w_idx;
        end else if (!o_valid_b) begin
          o_valid_b = 1'b1;
          o_idx_b   = w_idx;
        end
      end
    end

    // Moving past the last winner puts any stalled requesters first next cycle.
    if (o_valid_b) begin
      o_next_ptr = o_idx_b + core_idx_t'(1);
    end else if (o_valid_a) begin
      o_next_ptr = o_idx_a + core_idx_t'(1);
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - shares a dual-port instruction ROM among four cores
//
// Purpose: grants up to two fetch requests per cycle (round-robin), drives the
// winners' addresses onto ROM ports A/B, and returns each ROM word to its core
// one cycle later with a one-cycle valid pulse.
// Optional feature macro: ROM_ADDR_RANGE_CHECK_EN adds addr_error_core; a
// granted address with nonzero bits above the ROM range returns data 0 with an
// error pulse instead of the ROM word.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_core      in  [3:0]    per-core fetch request
//   address_coreN in  [WIDTH]  per-core fetch address
//   grant_core    out [3:0]    per-core accept (combinational)
//   data_coreN    out [WIDTH]  returned instruction, held until overwritten
//   valid_core    out [3:0]    data_coreN is new this cycle
//   rom_address_a/b out        ROM port addresses (0 when port unused)
//   rom_q_a/b     in  [WIDTH]  ROM read data, one cycle after address
//   addr_error_core out [3:0]  out-of-range pulse (feature build only)
module rom_port_arbiter #(
  parameter int WIDTH          = 32,
  parameter int ROM_ADDR_WIDTH = 14,
  parameter int NUM_CORES      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CORES-1:0]      req_core,
  input  logic [WIDTH-1:0]          address_core0,
  input  logic [WIDTH-1:0]          address_core1,
  input  logic [WIDTH-1:0]          address_core2,
  input  logic [WIDTH-1:0]          address_core3,
  output logic [NUM_CORES-1:0]      grant_core,
  output logic [WIDTH-1:0]          data_core0,
  output logic [WIDTH-1:0]          data_core1,
  output logic [WIDTH-1:0]          data_core2,
  output logic [WIDTH-1:0]          data_core3,
  output logic [NUM_CORES-1:0]      valid_core,
  output logic [ROM_ADDR_WIDTH-1:0] rom_address_a,
  output logic [ROM_ADDR_WIDTH-1:0] rom_address_b,
  input  logic [WIDTH-1:0]          rom_q_a,
  input  logic [WIDTH-1:0]          rom_q_b
`ifdef ROM_ADDR_RANGE_CHECK_EN
  ,
  output logic [NUM_CORES-1:0]      addr_error_core
`endif
);

  import rom_port_arbiter_pkg::*;

  logic [WIDTH-1:0] w_addr [NUM_CORES];
  logic [WIDTH-1:0] w_data [NUM_CORES];
  logic [WIDTH-1:0] r_data [NUM_CORES];
  logic [WIDTH-1:0] w_q_a;
  logic [WIDTH-1:0] w_q_b;

  core_idx_t     r_ptr;
  inflight_tag_t r_tag_a;
  inflight_tag_t r_tag_b;

  logic      w_valid_a;
  logic      w_valid_b;
  core_idx_t w_idx_a;
  core_idx_t w_idx_b;
  core_idx_t w_next_ptr;

  assign w_addr[0] = address_core0;
  assign w_addr[1] = address_core1;
  assign w_addr[2] = address_core2;
  assign w_addr[3] = address_core3;

  rr_pick2 u_pick (
    .i_req      (req_core),
    .i_ptr      (r_ptr),
    .o_valid_a  (w_valid_a),
    .o_idx_a    (w_idx_a),
    .o_valid_b  (w_valid_b),
    .o_idx_b    (w_idx_b),
    .o_next_ptr (w_next_ptr)
  );

  // Grants and ROM addresses are forced to 0 while reset is held so nothing
  // is handed out before the arbiter is live.
  always_comb begin
    grant_core    = '0;
    rom_address_a = '0;
    rom_address_b = '0;
    if (!reset) begin
      if (w_valid_a) begin
        grant_core[w_idx_a] = 1'b1;
        rom_address_a       = w_addr[w_idx_a][ROM_ADDR_WIDTH-1:0];
      end
      if (w_valid_b) begin
        grant_core[w_idx_b] = 1'b1;
        rom_address_b       = w_addr[w_idx_b][ROM_ADDR_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_tag_a <= '0;
      r_tag_b <= '0;
    end else begin
      r_ptr   <= w_next_ptr;
      r_tag_a <= '{valid: w_valid_a, core: w_idx_a};
      r_tag_b <= '{valid: w_valid_b, core: w_idx_b};
    end
  end

`ifdef ROM_ADDR_RANGE_CHECK_EN
  logic r_err_a;
  logic r_err_b;
  logic w_err_a;
  logic w_err_b;

  assign w_err_a = w_valid_a && (|w_addr[w_idx_a][WIDTH-1:ROM_ADDR_WIDTH]);
  assign w_err_b = w_valid_b && (|w_addr[w_idx_b][WIDTH-1:ROM_ADDR_WIDTH]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_a <= 1'b0;
      r_err_b <= 1'b0;
    end else begin
      r_err_a <= w_err_a;
      r_err_b <= w_err_b;
    end
  end

  // An out-of-range slot still reads the ROM; its word is replaced by 0.
  assign w_q_a = r_err_a ? '0 : rom_q_a;
  assign w_q_b = r_err_b ? '0 : rom_q_b;

  always_comb begin
    addr_error_core = '0;
    if (r_tag_a.valid && r_err_a) addr_error_core[r_tag_a.core] = 1'b1;
    if (r_tag_b.valid && r_err_b) addr_error_core[r_tag_b.core] = 1'b1;
  end
`else
  logic w_unused;

  assign w_q_a    = rom_q_a;
  assign w_q_b    = rom_q_b;
  assign w_unused = ^{address_core0[WIDTH-1:ROM_ADDR_WIDTH],
                      address_core1[WIDTH-1:ROM_ADDR_WIDTH],
                      address_core2[WIDTH-1:ROM_ADDR_WIDTH],
                      address_core3[WIDTH-1:ROM_ADDR_WIDTH]};
`endif

  // The ROM word only exists during N+1, so it is passed straight through to
  // the tagged core that cycle and captured so the output holds afterwards.
  always_comb begin
    valid_core = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_data[i] = r_data[i];
    end
    if (r_tag_a.valid) begin
      valid_core[r_tag_a.core] = 1'b1;
      w_data[r_tag_a.core]     = w_q_a;
    end
    if (r_tag_b.valid) begin
      valid_core[r_tag_b.core] = 1'b1;
      w_data[r_tag_b.core]     = w_q_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        r_data[i] <= w_data[i];
      end
    end
  end

  assign data_core0 = w_data[0];
  assign data_core1 = w_data[1];
  assign data_core2 = w_data[2];
  assign data_core3 = w_data[3];

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb/tb_rom_port_arbiter.sv - scoreboard bench for rom_port_arbiter
module tb_rom_port_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_core;
  logic [31:0] address_core0, address_core1, address_core2, address_core3;
  logic [3:0]  grant_core;
  logic [31:0] data_core0, data_core1, data_core2, data_core3;
  logic [3:0]  valid_core;
  logic [13:0] rom_address_a, rom_address_b;
  logic [31:0] rom_q_a, rom_q_b;
`ifdef ROM_ADDR_RANGE_CHECK_EN
  logic [3:0]  addr_error_core;
`endif

  rom_port_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req_core      (req_core),
    .address_core0 (address_core0),
    .address_core1 (address_core1),
    .address_core2 (address_core2),
    .address_core3 (address_core3),
    .grant_core    (grant_core),
    .data_core0    (data_core0),
    .data_core1    (data_core1),
    .data_core2    (data_core2),
    .data_core3    (data_core3),
    .valid_core    (valid_core),
    .rom_address_a (rom_address_a),
    .rom_address_b (rom_address_b),
    .rom_q_a       (rom_q_a),
    .rom_q_b       (rom_q_b)
`ifdef ROM_ADDR_RANGE_CHECK_EN
    ,
    .addr_error_core (addr_error_core)
`endif
  );

  typedef struct {
    int          due;
    int          core;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          m_ptr    = 0;
  logic [3:0]  pend;
  logic [31:0] addr [4];
  logic [31:0] dcore [4];

  assign dcore[0] = data_core0;
  assign dcore[1] = data_core1;
  assign dcore[2] = data_core2;
  assign dcore[3] = data_core3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] rom_word(input logic [13:0] a);
    if (a == 14'd5) return 32'h0000_A5A5;
    return {2'b10, a, 2'b01, ~a};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ROM with a registered read: address seen in cycle N, word present in N+1.
  initial begin
    logic [13:0] sa, sb;
    rom_q_a = '0;
    rom_q_b = '0;
    forever begin
      @(negedge clk);
      sa = rom_address_a;
      sb = rom_address_b;
      @(posedge clk);
      #1;
      rom_q_a = rom_word(sa);
      rom_q_b = rom_word(sb);
    end
  end

  // Monitor: every cycle the DUT's valid/data/error outputs must match the
  // responses the stimulus side scheduled for this cycle.
  initial begin
    logic [31:0] last [4];
    logic [31:0] edata [4];
    logic [3:0]  emask;
    exp_t        e;
`ifdef ROM_ADDR_RANGE_CHECK_EN
    logic [3:0]  eerr;
`endif
    for (int c = 0; c < 4; c++) last[c] = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("valid_in_reset", {28'd0, valid_core}, 32'd0);
        for (int c = 0; c < 4; c++) last[c] = '0;
      end else begin
        emask = '0;
`ifdef ROM_ADDR_RANGE_CHECK_EN
        eerr = '0;
`endif
        for (int c = 0; c < 4; c++) edata[c] = last[c];
        while (expq.size() > 0 && expq[0].due <= cyc) begin
          e = expq.pop_front();
          emask[e.core] = 1'b1;
          edata[e.core] = e.data;
`ifdef ROM_ADDR_RANGE_CHECK_EN
          eerr[e.core] = e.err;
`endif
        end
        check("valid_core", {28'd0, valid_core}, {28'd0, emask});
        for (int c = 0; c < 4; c++) begin
          check($sformatf("data_core%0d", c), dcore[c], edata[c]);
          last[c] = edata[c];
        end
`ifdef ROM_ADDR_RANGE_CHECK_EN
        check("addr_error_core", {28'd0, addr_error_core}, {28'd0, eerr});
`endif
      end
    end
  end

  // One arbitration cycle: present pending requests, predict the winners from
  // the rotating priority order, and schedule their responses for next cycle.
  task automatic step(output logic [3:0] g);
    int          order[$];
    int          nwin;
    logic [3:0]  eg;
    logic [13:0] ea, eb;
    exp_t        e;
    @(posedge clk);
    #1;
    req_core      = pend;
    address_core0 = addr[0];
    address_core1 = addr[1];
    address_core2 = addr[2];
    address_core3 = addr[3];
    #2;
    for (int k = 0; k < 4; k++) begin
      if (pend[(m_ptr + k) % 4]) order.push_back((m_ptr + k) % 4);
    end
    nwin = (order.size() > 2) ? 2 : order.size();
    eg = '0;
    ea = '0;
    eb = '0;
    if (nwin >= 1) ea = addr[order[0]][13:0];
    if (nwin == 2) eb = addr[order[1]][13:0];
    for (int i = 0; i < nwin; i++) eg[order[i]] = 1'b1;
    check("grant_core", {28'd0, grant_core}, {28'd0, eg});
    check("rom_address_a", {18'd0, rom_address_a}, {18'd0, ea});
    check("rom_address_b", {18'd0, rom_address_b}, {18'd0, eb});
    for (int i = 0; i < nwin; i++) begin
      e.due  = cyc + 1;
      e.core = order[i];
`ifdef ROM_ADDR_RANGE_CHECK_EN
      e.err  = |addr[order[i]][31:14];
      e.data = e.err ? 32'd0 : rom_word(addr[order[i]][13:0]);
`else
      e.err  = 1'b0;
      e.data = rom_word(addr[order[i]][13:0]);
`endif
      expq.push_back(e);
      pend[order[i]] = 1'b0;
    end
    if (nwin > 0) m_ptr = (order[nwin-1] + 1) % 4;
    g = grant_core;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    req_core = '0;
    pend     = '0;
    m_ptr    = 0;
    expq.delete();
    #2;
    check("rst_grant", {28'd0, grant_core}, 32'd0);
    check("rst_valid", {28'd0, valid_core}, 32'd0);
    check("rst_rom_a", {18'd0, rom_address_a}, 32'd0);
    check("rst_rom_b", {18'd0, rom_address_b}, 32'd0);
    for (int c = 0; c < 4; c++) check("rst_data", dcore[c], 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] tbl [4];
    tbl[0] = 4'b0011;
    tbl[1] = 4'b1100;
    tbl[2] = 4'b0011;
    tbl[3] = 4'b1100;
    reset         = 1'b1;
    req_core      = 4'hF;
    address_core0 = '0;
    address_core1 = '0;
    address_core2 = '0;
    address_core3 = '0;
    pend          = '0;
    for (int c = 0; c < 4; c++) addr[c] = '0;
    #3;
    check("init_grant_in_reset", {28'd0, grant_core}, 32'd0);
    check("init_rom_a", {18'd0, rom_address_a}, 32'd0);
    check("init_valid", {28'd0, valid_core}, 32'd0);
    req_core = '0;
    do_reset();

    // Single request
    addr[0] = 32'h5;
    pend    = 4'b0001;
    step(g);
    check("t1_grant", {28'd0, g}, 32'h1);
    step(g);
    check("t1_valid", {28'd0, valid_core}, 32'h1);
    check("t1_data", data_core0, 32'h0000_A5A5);
    check("t1_rom_b_idle", {18'd0, rom_address_b}, 32'd0);

    // Two requests from pointer 0, then wrap from pointer 3
    do_reset();
    addr[1] = 32'd100;
    addr[2] = 32'd200;
    pend    = 4'b0110;
    step(g);
    check("t2_grant", {28'd0, g}, 32'h6);
    addr[3] = 32'h30;
    addr[0] = 32'h40;
    pend    = 4'b1001;
    step(g);
    check("t3_grant", {28'd0, g}, 32'h9);
    check("t3_rom_a_core3", {18'd0, rom_address_a}, 32'h30);
    check("t3_rom_b_core0", {18'd0, rom_address_b}, 32'h40);
    repeat (2) step(g);

    // Full contention
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 4; c++) addr[c] = 32'(c * 16 + i);
      pend = 4'hF;
      step(g);
      check($sformatf("t4_grant%0d", i), {28'd0, g}, {28'd0, tbl[i]});
    end
    repeat (3) step(g);

    // Reset while a response is in flight
    do_reset();
    addr[2] = 32'd7;
    pend    = 4'b0100;
    step(g);
    step(g);
    addr[2] = 32'd9;
    pend    = 4'b0100;
    step(g);
    @(posedge clk);
    #1;
    req_core = '0;
    #1;
    reset = 1'b1;
    expq.delete();
    pend  = '0;
    m_ptr = 0;
    #1;
    check("t5_valid", {28'd0, valid_core}, 32'd0);
    check("t5_data2", data_core2, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) step(g);
    pend = 4'hF;
    step(g);
    check("t5_ptr0_grant", {28'd0, g}, 32'h3);
    repeat (3) step(g);

    // Address with bits above the ROM range
    addr[1] = 32'h0001_0003;
    pend    = 4'b0010;
    step(g);
    step(g);
`ifdef ROM_ADDR_RANGE_CHECK_EN
    check("t6_err", {28'd0, addr_error_core}, 32'h2);
    check("t6_data", data_core1, 32'd0);
`else
    check("t6_data", data_core1, rom_word(14'd3));
`endif
    check("t6_valid", {28'd0, valid_core}, 32'h2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (!pend[c] && $urandom_range(0, 99) < 55) begin
          pend[c] = 1'b1;
          if ($urandom_range(0, 9) < 8) addr[c] = 32'($urandom_range(0, 16383));
          else addr[c] = $urandom;
        end
      end
      step(g);
    end

    // Drain
    for (int n = 0; n < 8; n++) step(g);
    check("pending_drained", {28'd0, pend}, 32'd0);
    check("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
